// File: rtl/instruction_fetcher_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : instruction_fetcher_pkg                                    |
// | Description : Shared types and constants for the instruction fetcher.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package instruction_fetcher_pkg;

  // Instruction word width delivered to the decoder.
  localparam int ILEN       = 32;
  // Native address width of the fetch path.
  localparam int FETCH_XLEN = 64;

  // One buffered fetch result: the word together with the PC it came from.
  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [ILEN-1:0]       code;
  } fetch_entry_t;

  // Width of a counter that must be able to hold the value DEPTH itself.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_fetcher_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : instruction_fetcher_fifo                                   |
// | Description : Generic synchronous FIFO with occupancy count and a        |
// |               synchronous clear that overrides push and pop.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module instruction_fetcher_fifo
  import instruction_fetcher_pkg::*;
#(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        arst_ni,
  input  logic                        clr_i,
  input  logic                        push_i,
  input  logic [WIDTH-1:0]            data_i,
  input  logic                        pop_i,
  output logic [WIDTH-1:0]            data_o,
  output logic                        empty_o,
  output logic [cnt_width(DEPTH)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  logic w_empty;
  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_depth);
  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign w_do_push = push_i & (~w_full | pop_i);
  assign w_do_pop  = pop_i & ~w_empty;

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk_i) begin
    if (w_do_push && !clr_i) begin
      r_mem[r_wptr] <= data_i;
    end
  end

  // Pointers and occupancy; the clear discards everything including this cycle's traffic.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (clr_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign data_o  = r_mem[r_rptr];
  assign empty_o = w_empty;
  assign count_o = r_count;

endmodule
`default_nettype wire

// File: rtl/instruction_fetcher.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : instruction_fetcher                                        |
// | Description : Issues in-order word fetches, buffers returned words with  |
// |               their PC and hands them to decode on a valid/ready         |
// |               handshake. A flush redirects fetch and drops stale words.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module instruction_fetcher
  import instruction_fetcher_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic            clk_i,
  input  logic            arst_ni,
  input  logic            flush_i,
  input  logic [XLEN-1:0] flush_pc_i,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [ILEN-1:0] mem_rdata_i,
  output logic [ILEN-1:0] code_o,
  output logic [XLEN-1:0] pc_o,
  output logic            valid_o,
  input  logic            ready_i
);

  localparam int CW = cnt_width(DEPTH);
  localparam int EW = XLEN + ILEN;
  localparam logic [CW:0]     c_depth = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] c_step  = XLEN'(4);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [CW-1:0]   r_inflight;
  logic [CW-1:0]   r_drop;

  logic [CW-1:0]   w_count;
  logic            w_empty;
  logic [EW-1:0]   w_head;
  logic [EW-1:0]   w_push_entry;
  logic [CW:0]     w_credit_sum;
  logic            w_req;
  logic            w_grant;
  logic            w_resp_drop;
  logic            w_push;
  logic            w_valid;
  logic            w_pop;
  logic [CW-1:0]   w_inflight_nxt;
  logic [XLEN-1:0] w_flush_pc;

  // Every request granted or word buffered consumes one credit out of DEPTH,
  // so the queue can never overflow. Reset also masks the request combinationally.
  assign w_credit_sum = {1'b0, r_inflight} + {1'b0, w_count};
  assign w_req        = arst_ni & ~flush_i & (w_credit_sum < c_depth);
  assign w_grant      = w_req & mem_gnt_i;

  // Responses owed to a pre-flush PC stream are discarded while drop is non-zero.
  assign w_resp_drop  = mem_rvalid_i & (r_drop != '0);
  assign w_push       = mem_rvalid_i & (r_drop == '0) & ~flush_i;

  assign w_valid      = ~w_empty & ~flush_i;
  assign w_pop        = w_valid & ready_i;

  assign w_inflight_nxt = r_inflight + CW'(w_grant) - CW'(mem_rvalid_i);
  assign w_flush_pc     = {flush_pc_i[XLEN-1:2], 2'b00};
  assign w_push_entry   = {r_resp_pc, mem_rdata_i};

  // Fetch PC advances on grant; a flush redirects both request and response PCs.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_pc      <= RESET_PC;
      r_resp_pc <= RESET_PC;
    end else if (flush_i) begin
      r_pc      <= w_flush_pc;
      r_resp_pc <= w_flush_pc;
    end else begin
      if (w_grant) begin
        r_pc <= r_pc + c_step;
      end
      if (w_push) begin
        r_resp_pc <= r_resp_pc + c_step;
      end
    end
  end

  // Outstanding-request and drop accounting. Drop never exceeds inflight, so
  // on a flush every request still outstanding after this cycle becomes a drop;
  // this also accumulates correctly over back-to-back flushes.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_inflight <= '0;
      r_drop     <= '0;
    end else begin
      r_inflight <= w_inflight_nxt;
      if (flush_i) begin
        r_drop <= w_inflight_nxt;
      end else begin
        r_drop <= r_drop - CW'(w_resp_drop);
      end
    end
  end

  instruction_fetcher_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .clr_i   (flush_i),
    .push_i  (w_push),
    .data_i  (w_push_entry),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  assign mem_req_o  = w_req;
  assign mem_addr_o = r_pc;
  assign valid_o    = w_valid;
  assign code_o     = w_empty ? '0 : w_head[ILEN-1:0];
  assign pc_o       = w_empty ? '0 : w_head[EW-1:ILEN];

endmodule
`default_nettype wire
